mesh_term_port: RTL and testbench

Per-terminal edge adapter between a host agent and one external port of `mesh_emu`. It is a neighbouring stage on both sides of the mesh edge:
- On the TX side it buffers host packets and drives the mesh `data_out_i_in` / `pndng_i_in` pair, honouring `popin`.
- On the RX side it drains the mesh `data_out` / `pndng` pair through a pop handshake into a local FIFO.
- Optionally, it checks that each received packet is addressed to this terminal.

One instance sits on each of the `ROWS*2+COLUMS*2` edge ports.

---
 rtl/mesh_pkg.sv | 26 ++
 rtl/mesh_term_fifo.sv | 52 +++++
 rtl/mesh_term_port.sv | 119 +++++++++++
 tb/tb_mesh_term_port.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh edge terminal: packet header layout,
// the RX handshake state encoding and header field extractors.
package mesh_pkg;

    localparam int ID_W     = 8;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 4;
    localparam int HDR_W    = ID_W + ROW_W + COL_W;
    // Mode bit sits directly below the header, counted down from the packet MSB
    localparam int MODE_BIT = HDR_W;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_POP,
        RX_CAP
    } rx_state_t;

    function automatic logic [ROW_W-1:0] pkt_row(input logic [HDR_W-1:0] hdr);
        return hdr[COL_W +: ROW_W];
    endfunction

    function automatic logic [COL_W-1:0] pkt_col(input logic [HDR_W-1:0] hdr);
        return hdr[0 +: COL_W];
    endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Power-of-two FIFO with combinational head; head reads zero while empty.
// A push is accepted when full only if a pop is honoured in the same cycle.
module mesh_term_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mesh_term_port.sv
// Edge adapter between a host agent and one mesh_emu port: buffered TX toward
// the mesh, pop-handshake RX into a local FIFO. Option: MESH_TERM_ADDR_CHECK_EN.
module mesh_term_port
    import mesh_pkg::*;
#(
    parameter int PCKG_SZ  = 40,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int MY_ROW   = 0,
    parameter int MY_COL   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_push,
    input  logic [PCKG_SZ-1:0] tx_data,
    output logic               tx_full,
    output logic [PCKG_SZ-1:0] mesh_data,
    output logic               mesh_pndng,
    input  logic               mesh_popin,
    input  logic [PCKG_SZ-1:0] mesh_out,
    input  logic               mesh_out_pndng,
    output logic               mesh_pop,
    input  logic               rx_pop,
    output logic [PCKG_SZ-1:0] rx_data,
    output logic               rx_valid,
    output logic [15:0]        rx_drop_cnt
`ifdef MESH_TERM_ADDR_CHECK_EN
    ,
    output logic [15:0]        addr_err_cnt
`endif
);

    if (MY_ROW < 0 || MY_ROW >= (1 << ROW_W) || MY_COL < 0 || MY_COL >= (1 << COL_W)) begin : g_bad_id
        $error("mesh_term_port: MY_ROW/MY_COL out of range");
    end

    rx_state_t state_q;
    rx_state_t state_d;
    logic      tx_empty;
    logic      rx_empty;
    logic      rx_full;
    logic      capture;
    logic      drop;

    mesh_term_fifo #(.W(PCKG_SZ), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (mesh_popin),
        .din   (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .head  (mesh_data)
    );

    assign mesh_pndng = !tx_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    // Pop and capture are a fixed three-cycle sequence; pndng is only looked at in IDLE
    always_comb begin
        state_d  = state_q;
        mesh_pop = 1'b0;
        capture  = 1'b0;
        unique case (state_q)
            RX_IDLE: if (mesh_out_pndng) state_d = RX_POP;
            RX_POP: begin
                mesh_pop = 1'b1;
                state_d  = RX_CAP;
            end
            RX_CAP: begin
                capture = 1'b1;
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    mesh_term_fifo #(.W(PCKG_SZ), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (rx_pop),
        .din   (mesh_out),
        .full  (rx_full),
        .empty (rx_empty),
        .head  (rx_data)
    );

    assign rx_valid = !rx_empty;
    assign drop     = capture && rx_full && !rx_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rx_drop_cnt <= '0;
        else if (drop && rx_drop_cnt != 16'hFFFF)
            rx_drop_cnt <= rx_drop_cnt + 1'b1;
    end

`ifdef MESH_TERM_ADDR_CHECK_EN
    logic [HDR_W-1:0] hdr;
    logic             addr_miss;

    assign hdr       = mesh_out[PCKG_SZ-1 -: HDR_W];
    assign addr_miss = (pkt_row(hdr) != ROW_W'(MY_ROW)) || (pkt_col(hdr) != COL_W'(MY_COL));

    // Misaddressed packets are only counted; they are still stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr_err_cnt <= '0;
        else if (capture && addr_miss && addr_err_cnt != 16'hFFFF)
            addr_err_cnt <= addr_err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_mesh_term_port.sv
// Scoreboard bench for mesh_term_port: TX ordering and full handling, RX pop
// cadence, overflow drops, destination checking and reset during a pop.
module tb_mesh_term_port;

    localparam int PW = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_push = 1'b0;
    logic [PW-1:0] tx_data = '0;
    logic          tx_full;
    logic [PW-1:0] mesh_data;
    logic          mesh_pndng;
    logic          mesh_popin = 1'b0;
    logic [PW-1:0] mesh_out = '0;
    logic          mesh_out_pndng = 1'b0;
    logic          mesh_pop;
    logic          rx_pop = 1'b0;
    logic [PW-1:0] rx_data;
    logic          rx_valid;
    logic [15:0]   rx_drop_cnt;
`ifdef MESH_TERM_ADDR_CHECK_EN
    logic [15:0]   addr_err_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [PW-1:0] tx_q[$];
    logic [PW-1:0] rx_q[$];
    int            rx_cnt   = 0;
    int            exp_drop = 0;
    int            exp_err  = 0;

    mesh_term_port #(
        .PCKG_SZ  (PW),
        .TX_DEPTH (8),
        .RX_DEPTH (8),
        .MY_ROW   (2),
        .MY_COL   (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_push        (tx_push),
        .tx_data        (tx_data),
        .tx_full        (tx_full),
        .mesh_data      (mesh_data),
        .mesh_pndng     (mesh_pndng),
        .mesh_popin     (mesh_popin),
        .mesh_out       (mesh_out),
        .mesh_out_pndng (mesh_out_pndng),
        .mesh_pop       (mesh_pop),
        .rx_pop         (rx_pop),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_drop_cnt    (rx_drop_cnt)
`ifdef MESH_TERM_ADDR_CHECK_EN
        ,
        .addr_err_cnt   (addr_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pushTx(input logic [PW-1:0] data, input bit accept);
        @(negedge clk);
        tx_push = 1'b1;
        tx_data = data;
        if (accept) tx_q.push_back(data);
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic popTx();
        logic [PW-1:0] exp;
        @(negedge clk);
        checkOutput("tx_pndng", mesh_pndng, 1);
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : '0;
        checkOutput("tx_data", mesh_data, exp);
        mesh_popin = 1'b1;
        @(negedge clk);
        mesh_popin = 1'b0;
    endtask

    // Offer n packets; each new value is presented on the pop cycle so it is what gets captured
    task automatic feedRx(input int n, input logic [PW-1:0] base, input logic [PW-1:0] step);
        int sent = 0;
        int cyc  = 0;
        int last = -1;
        logic [PW-1:0] pkt;
        mesh_out_pndng = 1'b1;
        while (sent < n && cyc < 12 * n + 20) begin
            @(negedge clk);
            cyc++;
            if (mesh_pop) begin
                if (last >= 0) checkOutput("pop_spacing", 64'(cyc - last), 3);
                last = cyc;
                pkt = base + step * PW'(sent);
                mesh_out = pkt;
                if (rx_cnt < 8) begin
                    rx_q.push_back(pkt);
                    rx_cnt++;
                end else begin
                    exp_drop++;
                end
                if (pkt[31:28] != 4'd2 || pkt[27:24] != 4'd3) exp_err++;
                sent++;
                if (sent == n) mesh_out_pndng = 1'b0;
            end
        end
        mesh_out_pndng = 1'b0;
        if (sent < n) checkOutput("feed_timeout", 64'(sent), 64'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic drainRx(input int n);
        logic [PW-1:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("rx_valid", rx_valid, 1);
            exp = (rx_q.size() > 0) ? rx_q.pop_front() : '0;
            checkOutput("rx_data", rx_data, exp);
            rx_pop = 1'b1;
            @(negedge clk);
            rx_pop = 1'b0;
            rx_cnt--;
        end
        @(negedge clk);
        checkOutput("rx_empty", rx_valid, 0);
    endtask

    task automatic checkCounters();
        checkOutput("rx_drop_cnt", rx_drop_cnt, 64'(exp_drop));
`ifdef MESH_TERM_ADDR_CHECK_EN
        checkOutput("addr_err_cnt", addr_err_cnt, 64'(exp_err));
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_full"}, tx_full, 0);
        checkOutput({tag, "_mesh_pndng"}, mesh_pndng, 0);
        checkOutput({tag, "_mesh_data"}, mesh_data, 0);
        checkOutput({tag, "_mesh_pop"}, mesh_pop, 0);
        checkOutput({tag, "_rx_valid"}, rx_valid, 0);
        checkOutput({tag, "_rx_data"}, rx_data, 0);
        checkCounters();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;

        for (int i = 1; i <= 3; i++) pushTx(40'h01110AAAA0 + PW'(i), 1'b1);
        @(negedge clk);
        checkOutput("tx_head_first", mesh_data, 40'h01110AAAA1);
        for (int i = 0; i < 3; i++) popTx();
        @(negedge clk);
        checkOutput("tx_drained", mesh_pndng, 0);

        for (int i = 0; i < 8; i++) pushTx(40'h5500000000 + PW'(i), 1'b1);
        @(negedge clk);
        checkOutput("tx_full_at_8", tx_full, 1);
        pushTx(40'h55000000FF, 1'b0);
        checkOutput("tx_full_after_9", tx_full, 1);
        for (int i = 0; i < 8; i++) popTx();
        @(negedge clk);
        checkOutput("tx_empty_after_8", mesh_pndng, 0);
        checkOutput("tx_not_full", tx_full, 0);

        feedRx(3, 40'hFF230BEEF1, 40'h0);
        checkCounters();
        drainRx(3);

        feedRx(2, 40'hFF210BEEF1, 40'h0);
        checkCounters();
        drainRx(2);

        feedRx(10, 40'hFF230C0000, 40'h1);
        checkCounters();
        drainRx(8);

        pushTx(40'h0102030405, 1'b1);
        mesh_out_pndng = 1'b1;
        mesh_out = 40'hFF23000001;
        waited = 0;
        while (!mesh_pop && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("pop_before_reset", mesh_pop, 1);
        #1 rst = 1'b1;
        #1;
        tx_q.delete();
        rx_q.delete();
        rx_cnt = 0;
        exp_drop = 0;
        exp_err = 0;
        mesh_out_pndng = 1'b0;
        checkResetValues("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("lost_after_reset", rx_valid, 0);
        checkOutput("pop_after_reset", mesh_pop, 0);
        checkCounters();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
